// File: rtl/clk_div_checker.sv
// Divided-clock checker: measures div_in period against DIV, tracks lock and counts errors.
// Optional high-phase (duty) check is enabled by defining CLK_DIV_CHECKER_DUTY_EN.
module clk_div_checker #(
    parameter int DIV      = 2,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {IDLE, MEAS, LOCK} state_t;

    localparam int TIMEOUT_I = 2 * DIV;
    localparam logic [CNT_W:0]   TIMEOUT = TIMEOUT_I[CNT_W:0];
    localparam logic [CNT_W-1:0] DIV_C   = DIV[CNT_W-1:0];
    localparam logic [3:0]       LOCK_C  = LOCK_CNT[3:0];

    state_t           r_state, w_state_next;
    logic             r_div_d;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_good_cnt, w_good_next;
    logic             r_locked, w_locked_next;
    logic             r_err, w_err_next;
    logic [CNT_W-1:0] r_period, w_period_next;
    logic [7:0]       r_err_cnt;

    logic w_rise;
    logic w_timeout;
    logic w_duty_ok;
    logic w_good_period;

    assign w_rise    = div_in & ~r_div_d;
    assign w_timeout = ({1'b0, r_cnt} == TIMEOUT);

`ifdef CLK_DIV_CHECKER_DUTY_EN
    localparam int HALF_I = DIV / 2;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_hi_len;

    // r_hi_len holds the length of the most recent completed high phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi_cnt <= '0;
            r_hi_len <= '0;
        end else begin
            if (w_rise)
                r_hi_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            else if (div_in && !(&r_hi_cnt))
                r_hi_cnt <= r_hi_cnt + 1'b1;
            if (!div_in && r_div_d)
                r_hi_len <= r_hi_cnt;
        end
    end

    assign w_duty_ok = (r_hi_len == HALF_I[CNT_W-1:0]);
`else
    assign w_duty_ok = 1'b1;
`endif

    assign w_good_period = (r_cnt == DIV_C) && w_duty_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_div_d    <= 1'b0;
            r_cnt      <= '0;
            r_good_cnt <= '0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_period   <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_div_d    <= div_in;
            r_good_cnt <= w_good_next;
            r_locked   <= w_locked_next;
            r_err      <= w_err_next;
            r_period   <= w_period_next;
            if (w_rise)
                r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            else if (!(&r_cnt))
                r_cnt <= r_cnt + 1'b1;
            if (w_err_next && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // An edge is evaluated before the timeout, so a coinciding pair yields one err.
    always_comb begin
        w_state_next  = r_state;
        w_good_next   = r_good_cnt;
        w_locked_next = r_locked;
        w_err_next    = 1'b0;
        w_period_next = r_period;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_next = MEAS;
                    w_good_next  = '0;
                end
            end
            MEAS, LOCK: begin
                if (w_rise) begin
                    w_period_next = r_cnt;
                    if (w_good_period) begin
                        if (r_state == MEAS) begin
                            if (r_good_cnt + 4'd1 >= LOCK_C) begin
                                w_state_next  = LOCK;
                                w_locked_next = 1'b1;
                                w_good_next   = '0;
                            end else begin
                                w_good_next = r_good_cnt + 4'd1;
                            end
                        end
                    end else begin
                        w_err_next    = 1'b1;
                        w_good_next   = '0;
                        w_locked_next = 1'b0;
                        w_state_next  = MEAS;
                    end
                end else if (w_timeout) begin
                    w_err_next    = 1'b1;
                    w_good_next   = '0;
                    w_locked_next = 1'b0;
                    w_state_next  = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign locked  = r_locked;
    assign err     = r_err;
    assign period  = r_period;
    assign err_cnt = r_err_cnt;

endmodule

// File: doc/clk_div_checker.md
CLK_DIV_CHECKER -- requirements
Module: clk_div_checker

Interface
REQ-001 The block SHALL have parameter DIV, default 2, meaning the expected divide ratio (even, 2..254).
REQ-002 The block SHALL have parameter LOCK_CNT, default 4, meaning consecutive good periods required to declare lock (1..15).
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the width of the period counter and period output.
REQ-004 The block SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port div_in  input  1  divided clock under test, generated synchronously from clk and treated as data.
REQ-007 The block SHALL have port locked  output  1  high while the measured period matches DIV.
REQ-008 The block SHALL have port err  output  1  one-cycle pulse on any period, duty or timeout violation.
REQ-009 The block SHALL have port period  output  CNT_W  last measured period in clk cycles.
REQ-010 The block SHALL have port err_cnt  output  8  saturating count of err pulses.

Function
REQ-011 The block SHALL register div_in once (div_d); a rising edge SHALL be the cycle where div_in=1 and div_d=0.
REQ-012 The counter cnt SHALL load 1 on a rising edge, otherwise increment, saturating at 2^CNT_W-1.
REQ-013 The FSM SHALL have three states: IDLE (wait for first edge), MEAS (counting good periods), LOCK.
REQ-014 IDLE SHALL move to MEAS on the first rising edge, with no period evaluated and no err.
REQ-015 In MEAS/LOCK, each rising edge SHALL evaluate the period: good if cnt==DIV, bad otherwise.
REQ-016 period SHALL take cnt at each evaluated edge, visible the cycle after the edge (1-cycle latency).
REQ-017 A good period in MEAS SHALL increment good_cnt; on reaching LOCK_CNT the FSM SHALL enter LOCK and assert locked on the same cycle period updates.
REQ-018 A bad period SHALL pulse err for exactly one cycle, clear good_cnt, deassert locked and go to MEAS.
REQ-019 Timeout: if cnt reaches 2*DIV without an edge in MEAS/LOCK, the block SHALL pulse err once, deassert locked, clear good_cnt and go to IDLE.
REQ-020 A stuck div_in SHALL generate only one timeout err until the next edge.
REQ-021 err_cnt SHALL increment on every err pulse and saturate at 255.
REQ-022 When an edge and a timeout coincide, the edge evaluation SHALL take priority and only one err SHALL be issued.

Reset
REQ-023 While rst=1 at a clk edge: state=IDLE, cnt=0, good_cnt=0, div_d=0, locked=0, err=0, period=0, err_cnt=0.
REQ-024 Reset asserted mid-measurement SHALL discard partial counts; the first edge after release SHALL be treated as in IDLE.

Configuration
REQ-025 Macro CLK_DIV_CHECKER_DUTY_EN SHALL enable a duty check: the high-phase length (cycles div_in=1 between rising and falling edge) SHALL equal DIV/2, or the period is bad (REQ-018).
REQ-026 Without CLK_DIV_CHECKER_DUTY_EN the block SHALL not check high time and SHALL have no high-time counter.

Verification
REQ-027 DIV=2, div_in toggling every clk after rst drops at 20 ns -> locked=1 after 4 good periods, period=2, err never pulses.
REQ-028 Locked at DIV=2, one period stretched to 3 cycles -> single err pulse, locked=0, err_cnt=1; relock after 4 good periods.
REQ-029 Locked, div_in held at 0 -> err pulse once at cnt=4, state IDLE, err_cnt=1, no further errs.
REQ-030 rst=1 for 1 cycle while locked -> all outputs 0 next cycle; relock takes 1 + LOCK_CNT periods.
REQ-031 DIV=4 with CLK_DIV_CHECKER_DUTY_EN, pattern high 1 / low 3 -> err every period, locked stays 0; without the macro -> locked=1.
REQ-032 Forced 300 errors -> err_cnt saturates at 255.
